counter_run_scheduler: RTL and testbench

//   Shares one prescaled 8-bit counter instance between NUM_REQ requesters.

---
 rtl/counter_run_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_counter_run_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_run_scheduler.sv
// -----------------------------------------------------------------------------
// counter_run_scheduler
//
// Shares one prescaled 8-bit counter between NUM_REQ requesters. A requester
// raises its req_i bit and holds it; the scheduler picks an owner round-robin,
// clears the counter, writes the prescaler phase, then enables it until the
// counter reaches the owner's target. The owner then gets a 1-cycle done pulse.
// Dropping the request before done aborts the run without a done pulse.
//
// Parameters
//   NUM_REQ        number of requesters (2..8)
//   PHASE_PRELOAD  prescaler phase loaded before each run (< CYCLES_PER_COUNT)
//
// Ports
//   clock_i       in   single clock, posedge
//   reset_i       in   asynchronous active-high reset
//   req_i         in   level requests, one bit per requester
//   target_i      in   packed 8-bit targets, requester k in [8k+7:8k]
//   grant_o       out  one-hot owner of the counter, 0 when idle
//   done_o        out  1-cycle pulse to the owner when the target is reached
//   busy_o        out  high whenever a run is in progress (not IDLE)
//   cnt_reset_o   out  synchronous clear to the counter
//   cnt_enable_o  out  count enable to the counter
//   cnt_write_o   out  phase write strobe to the counter
//   cnt_val_o     out  phase value written with cnt_write_o
//   count_i       in   current count from the counter
// -----------------------------------------------------------------------------
module counter_run_scheduler #(
    parameter int         NUM_REQ       = 4,
    parameter logic [7:0] PHASE_PRELOAD = 8'd0
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   target_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic                   busy_o,
    output logic                   cnt_reset_o,
    output logic                   cnt_enable_o,
    output logic                   cnt_write_o,
    output logic [7:0]             cnt_val_o,
    input  logic [7:0]             count_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PRELOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         tgt_q, tgt_d;

    // Round-robin pick, valid only while IDLE.
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [7:0]         pick_tgt;

    logic [NUM_REQ-1:0] owner;
    logic               owner_req;
    logic [IDX_W-1:0]   next_rr;

    // Search from the rr pointer upward with wrap; first set bit wins.
    always_comb begin : rr_search
        int cand;
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        cand     = 0;
        found    = 1'b0;
        pick     = '0;
        pick_tgt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                pick     = IDX_W'(cand);
                pick_tgt = target_i[8*cand +: 8];
            end
        end
    end

    assign owner     = NUM_REQ'(1) << idx_q;
    assign owner_req = |(req_i & owner);
    assign next_rr   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        idx_d        = idx_q;
        tgt_d        = tgt_q;
        grant_o      = '0;
        done_o       = '0;
        busy_o       = 1'b0;
        cnt_reset_o  = 1'b0;
        cnt_enable_o = 1'b0;
        cnt_write_o  = 1'b0;
        cnt_val_o    = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    idx_d   = pick;
                    tgt_d   = pick_tgt;
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                grant_o     = owner;
                busy_o      = 1'b1;
                cnt_reset_o = 1'b1;
                if (!owner_req) begin
                    rr_d    = next_rr;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_PRELOAD;
                end
            end

            S_PRELOAD: begin
                grant_o      = owner;
                busy_o       = 1'b1;
                cnt_enable_o = 1'b1;
                cnt_write_o  = 1'b1;
                cnt_val_o    = PHASE_PRELOAD;
                if (!owner_req) begin
                    rr_d    = next_rr;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                grant_o      = owner;
                busy_o       = 1'b1;
                // Combinational so the counter freezes on the very cycle it
                // shows the target and never steps past it.
                cnt_enable_o = (count_i != tgt_q);
                if (!owner_req) begin
                    // A withdrawn request wins over a simultaneous target hit.
                    rr_d    = next_rr;
                    state_d = S_IDLE;
                end else if (count_i == tgt_q) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                grant_o = owner;
                busy_o  = 1'b1;
                done_o  = owner;
                rr_d    = next_rr;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule

// File: tb/tb_counter_run_scheduler.sv
// -----------------------------------------------------------------------------
// tb_counter_run_scheduler
//
// Two scheduler instances, each driving a behavioural prescaled counter with
// CYCLES_PER_COUNT = 8: dut_a uses phase preload 0, dut_b uses phase preload 5.
// Completed runs of dut_a are checked against a scoreboard of expected
// owner, final count, enabled RUN cycles and setup cycles.
// -----------------------------------------------------------------------------
module tb_counter_run_scheduler;

    localparam int NREQ = 4;

    logic              clk;
    logic              rst;

    logic [NREQ-1:0]   req_a, req_b;
    logic [8*NREQ-1:0] tgt_a, tgt_b;
    logic [NREQ-1:0]   grant_a, grant_b, done_a, done_b;
    logic              busy_a, busy_b;
    logic              cnt_reset_a, cnt_enable_a, cnt_write_a;
    logic              cnt_reset_b, cnt_enable_b, cnt_write_b;
    logic [7:0]        cnt_val_a, cnt_val_b;
    logic [7:0]        count_a, count_b;
    logic [2:0]        ph_a, ph_b;

    int n_vec  = 0;
    int n_fail = 0;

    counter_run_scheduler #(.NUM_REQ(NREQ), .PHASE_PRELOAD(8'd0)) dut_a (
        .clock_i      (clk),
        .reset_i      (rst),
        .req_i        (req_a),
        .target_i     (tgt_a),
        .grant_o      (grant_a),
        .done_o       (done_a),
        .busy_o       (busy_a),
        .cnt_reset_o  (cnt_reset_a),
        .cnt_enable_o (cnt_enable_a),
        .cnt_write_o  (cnt_write_a),
        .cnt_val_o    (cnt_val_a),
        .count_i      (count_a)
    );

    counter_run_scheduler #(.NUM_REQ(NREQ), .PHASE_PRELOAD(8'd5)) dut_b (
        .clock_i      (clk),
        .reset_i      (rst),
        .req_i        (req_b),
        .target_i     (tgt_b),
        .grant_o      (grant_b),
        .done_o       (done_b),
        .busy_o       (busy_b),
        .cnt_reset_o  (cnt_reset_b),
        .cnt_enable_o (cnt_enable_b),
        .cnt_write_o  (cnt_write_b),
        .cnt_val_o    (cnt_val_b),
        .count_i      (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Prescaled counters: write loads the phase, count steps when phase wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_a <= '0;
            ph_a    <= '0;
        end else if (cnt_reset_a) begin
            count_a <= '0;
            ph_a    <= '0;
        end else if (cnt_write_a) begin
            ph_a <= cnt_val_a[2:0];
        end else if (cnt_enable_a) begin
            if (ph_a == 3'd7) begin
                ph_a    <= '0;
                count_a <= count_a + 8'd1;
            end else begin
                ph_a <= ph_a + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_b <= '0;
            ph_b    <= '0;
        end else if (cnt_reset_b) begin
            count_b <= '0;
            ph_b    <= '0;
        end else if (cnt_write_b) begin
            ph_b <= cnt_val_b[2:0];
        end else if (cnt_enable_b) begin
            if (ph_b == 3'd7) begin
                ph_b    <= '0;
                count_b <= count_b + 8'd1;
            end else begin
                ph_b <= ph_b + 3'd1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard of runs expected to complete on dut_a.
    typedef struct {
        logic [NREQ-1:0] grant;
        logic [7:0]      tgt;
        int              en;
    } exp_t;

    exp_t sb_q[$];
    int   mon_en  = 0;
    int   mon_clr = 0;
    int   mon_wr  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (busy_a && cnt_reset_a)                 mon_clr++;
        if (busy_a && cnt_write_a)                 mon_wr++;
        if (busy_a && cnt_enable_a && !cnt_write_a) mon_en++;
        if (done_a != '0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done_a), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("done_owner",     32'(done_a),  32'(e.grant));
                check("done_count",     32'(count_a), 32'(e.tgt));
                check("run_en_cycles",  mon_en,       e.en);
                check("clear_cycles",   mon_clr,      32'd1);
                check("preload_cycles", mon_wr,       32'd1);
                check("done_ctrl", 32'({cnt_reset_a, cnt_enable_a, cnt_write_a}), 32'd0);
            end
        end
        if (!busy_a || done_a != '0) begin
            mon_en  = 0;
            mon_clr = 0;
            mon_wr  = 0;
        end
    end

    typedef struct {
        logic [NREQ-1:0]   req;
        logic [8*NREQ-1:0] tgts;
        logic [NREQ-1:0]   grant;
        logic [7:0]        tgt;
        int                en;
        logic [NREQ-1:0]   req_after;
    } vec_t;

    vec_t vecs[8];

    // One complete run on dut_a; called at a negedge, returns at a negedge.
    task automatic run_txn(input vec_t v, input int id);
        exp_t e;
        int   lat;
        req_a   = v.req;
        tgt_a   = v.tgts;
        e.grant = v.grant;
        e.tgt   = v.tgt;
        e.en    = v.en;
        sb_q.push_back(e);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (grant_a != '0) break;
        end
        check($sformatf("grant_v%0d", id), 32'(grant_a), 32'(v.grant));
        lat = 0;
        while (done_a == '0 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        // CLEAR, PRELOAD, enabled RUN cycles, final RUN cycle, then DONE.
        check($sformatf("latency_v%0d", id), lat, v.en + 3);
        req_a = v.req_after;
        @(negedge clk);
        check($sformatf("idle_grant_v%0d", id), 32'(grant_a), 32'd0);
        check($sformatf("idle_busy_v%0d", id),  32'(busy_a),  32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_grant"}, 32'(grant_a), 32'd0);
        check({nm, "_done"},  32'(done_a),  32'd0);
        check({nm, "_busy"},  32'(busy_a),  32'd0);
        check({nm, "_ctrl"},  32'({cnt_reset_a, cnt_enable_a, cnt_write_a}), 32'd0);
        check({nm, "_val"},   32'(cnt_val_a), 32'd0);
    endtask

    task automatic reset_mid_run();
        req_a = 4'b0010;
        tgt_a = 32'h0000_0500;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (grant_a != '0) break;
        end
        check("rst_pre_grant", 32'(grant_a), 32'b0010);
        repeat (5) @(negedge clk);
        check("rst_pre_busy", 32'(busy_a), 32'd1);
        rst   = 1'b1;
        req_a = '0;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic abort_run();
        int k;
        req_a = 4'b0010;
        tgt_a = 32'h0000_0900;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (grant_a != '0) break;
        end
        check("abort_grant", 32'(grant_a), 32'b0010);
        k = 0;
        while (count_a != 8'd3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_count", 32'(count_a), 32'd3);
        req_a = '0;
        @(negedge clk);
        check("abort_idle_busy",  32'(busy_a),  32'd0);
        check("abort_idle_grant", 32'(grant_a), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'(busy_a), 32'd0);
    endtask

    task automatic preload_phase_run();
        int k;
        int en;
        req_b = 4'b0001;
        tgt_b = 32'h0000_0001;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (grant_b != '0) break;
        end
        check("p5_grant", 32'(grant_b), 32'b0001);
        en = 0;
        k  = 0;
        while (done_b == '0 && k < 200) begin
            if (cnt_enable_b && !cnt_write_b) en++;
            if (cnt_write_b) tgt_b = 32'h4040_4040;
            @(negedge clk);
            k++;
        end
        check("p5_done",   32'(done_b),  32'b0001);
        check("p5_count",  32'(count_b), 32'd1);
        check("p5_en_cyc", en,           32'd3);
        req_b = '0;
        @(negedge clk);
        check("p5_idle_grant", 32'(grant_b), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 32'h0000_0002, 4'b0001, 8'd2, 16, 4'b0000};
        vecs[1] = '{4'b1111, 32'h0101_0101, 4'b0001, 8'd1,  8, 4'b1111};
        vecs[2] = '{4'b1111, 32'h0101_0101, 4'b0010, 8'd1,  8, 4'b1111};
        vecs[3] = '{4'b1111, 32'h0101_0101, 4'b0100, 8'd1,  8, 4'b1111};
        vecs[4] = '{4'b1111, 32'h0101_0101, 4'b1000, 8'd1,  8, 4'b1111};
        vecs[5] = '{4'b1111, 32'h0101_0101, 4'b0001, 8'd1,  8, 4'b0000};
        vecs[6] = '{4'b0100, 32'h0000_0000, 4'b0100, 8'd0,  0, 4'b0000};
        vecs[7] = '{4'b0111, 32'h0101_0101, 4'b0100, 8'd1,  8, 4'b0000};

        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
        tgt_a = '0;
        tgt_b = '0;
        @(negedge clk);
        check_all_zero("reset");
        check("reset_b_busy", 32'(busy_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (i == 1) reset_mid_run();
            if (i == 7) abort_run();
            run_txn(vecs[i], i);
        end

        preload_phase_run();

        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
